// File: rtl/dsm_pkg.sv
// Shared delta-sigma definitions: MASH 1-1-1 sample type, its legal range and CIC width helper.
package dsm_pkg;

  localparam int MASH_Y_MIN = -3;
  localparam int MASH_Y_MAX = 4;

  typedef logic signed [3:0] mash_y_t;

  // Bit growth of an N-stage CIC is N*log2(R) on top of the 4-bit sample.
  function automatic int cic_out_w(input int log2_r, input int n_stages);
    return 4 + n_stages * log2_r;
  endfunction

endpackage

// File: rtl/dsm_cic_comb.sv
// One CIC comb stage: q = d - d_delayed, delay register loads on the decimated sample strobe.
module dsm_cic_comb #(
  parameter int W = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                ld_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [W-1:0] q_o
);

  logic signed [W-1:0] dly;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) dly <= '0;
    else if (ld_i)       dly <= d_i;
  end

  assign q_o = d_i - dly;

endmodule

// File: rtl/mash_sinc3_decim.sv
// Sinc^3 decimator recovering the fractional word from a MASH 1-1-1 output stream.
module mash_sinc3_decim
  import dsm_pkg::*;
#(
  parameter  int WIDTH  = 24,
  parameter  int LOG2_R = 8,
  localparam int OUT_W  = cic_out_w(LOG2_R, 3)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  mash_y_t                 y_i,
  output logic signed [OUT_W-1:0] x_o,
  output logic                    valid_o,
  output logic                    settled_o,
  output logic                    ovr_o
);

  if (3 * LOG2_R != WIDTH) begin : g_bad_ratio
    $error("mash_sinc3_decim: DC gain R^3 does not match 2^WIDTH");
  end

  logic signed [OUT_W-1:0] i1, i2, i3, i3_nxt, y_ext;
  logic signed [OUT_W-1:0] c [4];
  logic [LOG2_R-1:0]       cnt;
  logic [1:0]              vcnt;
  logic                    smp;

  assign y_ext  = {{(OUT_W-4){y_i[3]}}, y_i};
  assign smp    = en_i && (cnt == '1);
  // Sample the integrator including this cycle's update so the window holds only post-reset data.
  assign i3_nxt = i3 + i2;
  assign c[0]   = i3_nxt;

  for (genvar k = 0; k < 3; k++) begin : g_comb
    dsm_cic_comb #(.W(OUT_W)) u_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr_i),
      .ld_i  (smp),
      .d_i   (c[k]),
      .q_o   (c[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      cnt       <= '0;
      vcnt      <= '0;
      x_o       <= '0;
      valid_o   <= 1'b0;
      settled_o <= 1'b0;
      ovr_o     <= 1'b0;
    end else begin
      valid_o <= smp;
      if (en_i) begin
        // Modular accumulation; wrap is cancelled by the combs.
        i1  <= i1 + y_ext;
        i2  <= i2 + i1;
        i3  <= i3_nxt;
        cnt <= cnt + 1'b1;
        if (y_i == 4'sb1000) ovr_o <= 1'b1;
      end
      if (smp) begin
        x_o <= c[3];
        if (vcnt == 2'd2) settled_o <= 1'b1;
        else              vcnt      <= vcnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mash_sinc3_decim.sv
// Randomized self-checking bench; reference is the closed-form sinc^3 sum over accepted samples.
module tb_mash_sinc3_decim;
  localparam int LOG2_R = 8;
  localparam int R      = 1 << LOG2_R;
  localparam int OUT_W  = 4 + 3 * LOG2_R;

  logic clk = 1'b0;
  logic rst_n = 1'b0, en_i = 1'b0, clr_i = 1'b0;
  logic [3:0] y_i = '0;
  logic signed [OUT_W-1:0] x_o;
  logic valid_o, settled_o, ovr_o;

  mash_sinc3_decim #(.WIDTH(24), .LOG2_R(LOG2_R)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .y_i(y_i),
    .x_o(x_o), .valid_o(valid_o), .settled_o(settled_o), .ovr_o(ovr_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int ys[$];
  longint exp_x;
  bit exp_valid, exp_settled, exp_ovr;

  // S(m) = sum_{j<m} y_j * C(m-1-j, 2): the triple running sum after m samples.
  function automatic longint s_of(input int m);
    longint s = 0;
    for (int j = 0; j < m; j++)
      s += longint'(ys[j]) * longint'(m - 1 - j) * longint'(m - 2 - j) / 2;
    return s;
  endfunction

  function automatic longint xo();
    return longint'($signed(x_o));
  endfunction

  task automatic drive(input bit rst, input bit clr, input bit en, input int y);
    int n;
    rst_n = !rst; clr_i = clr; en_i = en; y_i = 4'(y);
    @(posedge clk); #1;
    exp_valid = 1'b0;
    if (rst || clr) begin
      ys.delete(); exp_x = 0; exp_settled = 0; exp_ovr = 0;
    end else if (en) begin
      ys.push_back(y);
      if (y == -8) exp_ovr = 1;
      n = ys.size();
      if (n % R == 0) begin
        exp_valid = 1;
        exp_x = s_of(n) - 3 * s_of(n - R) + 3 * s_of(n - 2 * R) - s_of(n - 3 * R);
        if (n >= 3 * R) exp_settled = 1;
      end
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 3);
    drive(1, 0, 1, 3);
    n_tests += 4;
    if (xo() !== 0)         begin n_fail++; $display("FAIL reset_x: got %0d want 0", xo()); end
    if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    if (settled_o !== 1'b0) begin n_fail++; $display("FAIL reset_settled: got %b want 0", settled_o); end
    if (ovr_o !== 1'b0)     begin n_fail++; $display("FAIL reset_ovr: got %b want 0", ovr_o); end
  endtask

  task automatic test_zero();
    int nv = 0;
    for (int i = 0; i < 5 * R; i++) begin
      drive(0, 0, 1, 0);
      n_tests += 2;
      if (valid_o !== exp_valid) begin n_fail++; $display("FAIL zero_valid: cyc %0d got %b want %b", i, valid_o, exp_valid); end
      if (xo() !== 0) begin n_fail++; $display("FAIL zero_x: cyc %0d got %0d want 0", i, xo()); end
      if (valid_o) begin
        nv++;
        n_tests++;
        if (settled_o !== (nv >= 3)) begin n_fail++; $display("FAIL zero_settled: pulse %0d got %b", nv, settled_o); end
      end
    end
    n_tests++;
    if (nv != 5) begin n_fail++; $display("FAIL zero_pulses: got %0d want 5", nv); end
  endtask

  task automatic test_dc();
    int yv[3] = '{1, -3, 4};
    longint want[3] = '{64'sd16777216, -64'sd50331648, 64'sd67108864};
    for (int t = 0; t < 3; t++) begin
      drive(0, 1, 0, 0);
      for (int i = 0; i < 8 * R; i++) begin
        drive(0, 0, 1, yv[t]);
        n_tests += 3;
        if (valid_o !== exp_valid) begin n_fail++; $display("FAIL dc_valid: y %0d cyc %0d got %b want %b", yv[t], i, valid_o, exp_valid); end
        if (xo() !== exp_x) begin n_fail++; $display("FAIL dc_x: y %0d cyc %0d got %0d want %0d", yv[t], i, xo(), exp_x); end
        if (settled_o !== exp_settled) begin n_fail++; $display("FAIL dc_settled: y %0d cyc %0d got %b", yv[t], i, settled_o); end
      end
      n_tests++;
      if (xo() !== want[t]) begin n_fail++; $display("FAIL dc_final: y %0d got %0d want %0d", yv[t], xo(), want[t]); end
    end
  endtask

  task automatic test_mash();
    longint acc1 = 0, acc2 = 0, acc3 = 0, sum = 0;
    int c1, c2, c3, c2d = 0, c3d = 0, c3dd = 0, y, nsum = 0;
    longint mean;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 68 * R && nsum < 64; i++) begin
      acc1 += 64'h400000;  c1 = int'(acc1 >> 24); acc1 &= 64'hFFFFFF;
      acc2 += acc1;        c2 = int'(acc2 >> 24); acc2 &= 64'hFFFFFF;
      acc3 += acc2;        c3 = int'(acc3 >> 24); acc3 &= 64'hFFFFFF;
      y = c1 + c2 - c2d + c3 - 2 * c3d + c3dd;
      c2d = c2; c3dd = c3d; c3d = c3;
      drive(0, 0, 1, y);
      n_tests += 2;
      if (valid_o !== exp_valid) begin n_fail++; $display("FAIL mash_valid: cyc %0d got %b want %b", i, valid_o, exp_valid); end
      if (xo() !== exp_x) begin n_fail++; $display("FAIL mash_x: cyc %0d got %0d want %0d", i, xo(), exp_x); end
      if (valid_o && settled_o) begin sum += xo(); nsum++; end
    end
    mean = (nsum > 0) ? sum / nsum : 0;
    n_tests += 2;
    if (nsum != 64) begin n_fail++; $display("FAIL mash_count: got %0d want 64", nsum); end
    if (mean < 4194304 - 16 || mean > 4194304 + 16) begin n_fail++; $display("FAIL mash_mean: got %0d want 4194304+-16", mean); end
  endtask

  task automatic test_random_en();
    int nv = 0, nen = 0, first_en = -1;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 20 * R && nv < 6; i++) begin
      bit en = ($urandom_range(0, 1) == 1);
      drive(0, 0, en, 2);
      if (en) nen++;
      n_tests += 2;
      if (valid_o !== exp_valid) begin n_fail++; $display("FAIL rnd_valid: cyc %0d got %b want %b", i, valid_o, exp_valid); end
      if (xo() !== exp_x) begin n_fail++; $display("FAIL rnd_x: cyc %0d got %0d want %0d", i, xo(), exp_x); end
      if (valid_o) begin nv++; if (first_en < 0) first_en = nen; end
    end
    n_tests += 3;
    if (first_en != R) begin n_fail++; $display("FAIL rnd_first: got %0d en samples want %0d", first_en, R); end
    if (nv != 6) begin n_fail++; $display("FAIL rnd_count: got %0d want 6", nv); end
    if (xo() !== 64'sd33554432) begin n_fail++; $display("FAIL rnd_final: got %0d want 33554432", xo()); end
  endtask

  task automatic test_clear();
    int nen = 0, first_en = -1;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 4 * R + 100; i++) drive(0, 0, 1, $urandom_range(0, 7) - 3);
    drive(0, 1, 1, 4);
    n_tests += 4;
    if (xo() !== 0)         begin n_fail++; $display("FAIL clr_x: got %0d want 0", xo()); end
    if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL clr_valid: got %b want 0", valid_o); end
    if (settled_o !== 1'b0) begin n_fail++; $display("FAIL clr_settled: got %b want 0", settled_o); end
    if (ovr_o !== 1'b0)     begin n_fail++; $display("FAIL clr_ovr: got %b want 0", ovr_o); end
    for (int i = 0; i < 3 * R; i++) begin
      drive(0, 0, 1, $urandom_range(0, 7) - 3);
      nen++;
      n_tests += 3;
      if (valid_o !== exp_valid) begin n_fail++; $display("FAIL clr2_valid: cyc %0d got %b want %b", i, valid_o, exp_valid); end
      if (xo() !== exp_x) begin n_fail++; $display("FAIL clr2_x: cyc %0d got %0d want %0d", i, xo(), exp_x); end
      if (settled_o !== exp_settled) begin n_fail++; $display("FAIL clr2_settled: cyc %0d got %b", i, settled_o); end
      if (valid_o && first_en < 0) first_en = nen;
    end
    n_tests += 2;
    if (first_en != R) begin n_fail++; $display("FAIL clr_first: got %0d want %0d", first_en, R); end
    if (settled_o !== 1'b1) begin n_fail++; $display("FAIL clr_resettle: got %b want 1", settled_o); end
    // Clear on the window-completing sample must suppress the pulse.
    for (int i = 0; i < R - 1; i++) drive(0, 0, 1, 1);
    drive(0, 1, 1, 1);
    n_tests += 2;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_edge_valid: got %b want 0", valid_o); end
    if (xo() !== 0) begin n_fail++; $display("FAIL clr_edge_x: got %0d want 0", xo()); end
    drive(0, 0, 1, 1);
    drive(0, 0, 1, -8);
    n_tests++;
    if (ovr_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr_o); end
    for (int i = 0; i < R; i++) begin
      drive(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) - 3);
      n_tests += 2;
      if (ovr_o !== exp_ovr) begin n_fail++; $display("FAIL ovr_sticky: cyc %0d got %b want %b", i, ovr_o, exp_ovr); end
      if (xo() !== exp_x) begin n_fail++; $display("FAIL ovr_x: cyc %0d got %0d want %0d", i, xo(), exp_x); end
    end
    drive(0, 1, 0, 0);
    n_tests++;
    if (ovr_o !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ovr_o); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_dc();
    test_mash();
    test_random_en();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
